// File: rtl/adc_phase_gen.sv
// adc_phase_gen: multi-phase clock divider off a single reference clock.
// A settle interval follows every reconfiguration. After it, NUM_CLKS
// divided clocks run, either evenly spaced or all aligned. Each clock has
// a strobe that marks its rising edge.
module adc_phase_gen #(
  parameter int unsigned NUM_CLKS    = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 10,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic                cfg_err,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] clk_en,
  output logic                locked
);

  localparam int unsigned LOG2N = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 0;
  localparam int unsigned PW    = DIV_W + 3;
  localparam int unsigned SCW   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  // Reject parameter sets that cannot produce a legal waveform
  if (!(NUM_CLKS == 1 || NUM_CLKS == 2 || NUM_CLKS == 4 || NUM_CLKS == 8)) begin : g_bad_num_clks
    $error("adc_phase_gen: NUM_CLKS must be 1, 2, 4 or 8");
  end
  if (DEFAULT_DIV < 2 || DEFAULT_DIV < NUM_CLKS) begin : g_bad_default_div
    $error("adc_phase_gen: DEFAULT_DIV must be >= 2 and >= NUM_CLKS");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("adc_phase_gen: LOCK_CYCLES must be >= 1");
  end

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic             mode_q;
  logic [DIV_W-1:0] cnt_q;
  logic [SCW-1:0]   settle_q;
  logic [DIV_W-1:0] off_q    [NUM_CLKS];

  logic [PW-1:0]       prod_c    [NUM_CLKS];
  logic [DIV_W-1:0]    off_calc_c[NUM_CLKS];
  logic [DIV_W-1:0]    off_use_c [NUM_CLKS];
  logic [DIV_W-1:0]    ph_c      [NUM_CLKS];
  logic [DIV_W-1:0]    cnt_use_c;
  logic [DIV_W-1:0]    cnt_nxt_c;
  logic [NUM_CLKS-1:0] oc_c;
  logic [NUM_CLKS-1:0] ce_c;
  logic                cfg_ok_c;
  logic                settle_done_c;

  // Per-channel offsets for the active configuration; the widened product cannot overflow
  always_comb begin
    for (int k = 0; k < NUM_CLKS; k++) begin
      prod_c[k]     = PW'(k) * PW'(div_q);
      off_calc_c[k] = mode_q ? '0 : DIV_W'(prod_c[k] >> LOG2N);
    end
  end

  // Next-cycle waveform values. The last settle cycle evaluates the cnt=0 point,
  // so the first locked cycle already shows the channel-0 rising edge.
  always_comb begin
    cnt_use_c = (state_q == SETTLE) ? '0 : cnt_q;
    cnt_nxt_c = (cnt_use_c == div_q - DIV_W'(1)) ? '0 : cnt_use_c + DIV_W'(1);
    oc_c      = '0;
    ce_c      = '0;
    for (int k = 0; k < NUM_CLKS; k++) begin
      off_use_c[k] = (state_q == SETTLE) ? off_calc_c[k] : off_q[k];
      ph_c[k]      = (cnt_use_c >= off_use_c[k]) ? (cnt_use_c - off_use_c[k])
                                                 : (cnt_use_c + div_q - off_use_c[k]);
      oc_c[k]      = (ph_c[k] < (div_q >> 1));
      ce_c[k]      = (ph_c[k] == '0);
    end
  end

  // Request legality and settle completion
  always_comb begin
    cfg_ok_c      = (cfg_div >= DIV_W'(2)) && (cfg_div >= DIV_W'(NUM_CLKS));
    settle_done_c = (settle_q == SCW'(LOCK_CYCLES - 1));
  end

  // Settle/locked state machine with the configuration, period counter and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= SETTLE;
      div_q     <= DIV_W'(DEFAULT_DIV);
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      settle_q  <= '0;
      for (int k = 0; k < NUM_CLKS; k++) off_q[k] <= '0;
      outclk    <= '0;
      clk_en    <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state_q)
        SETTLE: begin
          cnt_q <= '0;
          for (int k = 0; k < NUM_CLKS; k++) off_q[k] <= off_calc_c[k];
          if (settle_done_c) begin
            state_q   <= LOCKED;
            settle_q  <= '0;
            cnt_q     <= cnt_nxt_c;
            outclk    <= oc_c;
            clk_en    <= ce_c;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            settle_q  <= settle_q + SCW'(1);
            outclk    <= '0;
            clk_en    <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
          end
        end
        LOCKED: begin
          if (cfg_valid && cfg_ready && cfg_ok_c) begin
            // Accepted request: restart from a clean settle interval
            state_q   <= SETTLE;
            div_q     <= cfg_div;
            mode_q    <= cfg_mode;
            cnt_q     <= '0;
            settle_q  <= '0;
            outclk    <= '0;
            clk_en    <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
          end else begin
            // Keep running; a rejected request only raises the error pulse
            if (cfg_valid && cfg_ready) cfg_err <= 1'b1;
            cnt_q  <= cnt_nxt_c;
            outclk <= oc_c;
            clk_en <= ce_c;
          end
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_phase_gen.sv
// Directed bench for adc_phase_gen with default parameters.
module tb_adc_phase_gen;

  logic       refclk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic       cfg_err;
  logic [3:0] outclk;
  logic [3:0] clk_en;
  logic       locked;

  int total;
  int passed;

  adc_phase_gen #(
    .NUM_CLKS(4), .DIV_W(8), .DEFAULT_DIV(10), .LOCK_CYCLES(16)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .cfg_err  (cfg_err),
    .outclk   (outclk),
    .clk_en   (clk_en),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Expected waveform at t cycles after the locked edge, from offsets given by hand
  function automatic logic [3:0] exp_wave(input int d, input int o0, input int o1,
                                          input int o2, input int o3, input int t,
                                          input bit strobe);
    int off[4];
    int ph;
    logic [3:0] r;
    off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      ph = (t + 16 * d - off[k]) % d;
      r[k] = strobe ? (ph == 0) : (ph < d / 2);
    end
    return r;
  endfunction

  // Checks n consecutive locked cycles starting at phase time t0
  task automatic run_check(input string tag, input int d, input int o0, input int o1,
                           input int o2, input int o3, input int t0, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_outclk"}, 32'(outclk), 32'(exp_wave(d, o0, o1, o2, o3, t0 + i, 1'b0)));
      chk({tag, "_clk_en"}, 32'(clk_en), 32'(exp_wave(d, o0, o1, o2, o3, t0 + i, 1'b1)));
      chk({tag, "_locked"}, 32'(locked), 32'd1);
      chk({tag, "_ready"},  32'(cfg_ready), 32'd1);
      tick();
    end
  endtask

  // Sixteen quiet settle cycles, ending on the first locked cycle
  task automatic settle_wait(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_settle_locked"}, 32'(locked), 32'd0);
      chk({tag, "_settle_outclk"}, 32'(outclk), 32'd0);
      chk({tag, "_settle_clk_en"}, 32'(clk_en), 32'd0);
      chk({tag, "_settle_ready"},  32'(cfg_ready), 32'd0);
      tick();
    end
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    cfg_mode  = 1'b0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_outclk", 32'(outclk), 32'd0);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready",  32'(cfg_ready), 32'd0);
    chk("rst_err",    32'(cfg_err), 32'd0);

    // Release: 16 settle cycles, then div 10, offsets 0,2,5,7
    rst = 1'b0;
    settle_wait("rel");
    chk("rel_first_outclk", 32'(outclk), 32'h9);
    chk("rel_first_clk_en", 32'(clk_en), 32'h1);
    run_check("def", 10, 0, 2, 5, 7, 0, 30);

    // Rejected request (div 3 < 4): one error pulse, waveform unbroken
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    run_check("inv_pre", 10, 0, 2, 5, 7, 30, 1);
    cfg_valid = 1'b0;
    chk("inv_err_pulse", 32'(cfg_err), 32'd1);
    run_check("inv", 10, 0, 2, 5, 7, 31, 1);
    chk("inv_err_clear", 32'(cfg_err), 32'd0);
    run_check("inv_post", 10, 0, 2, 5, 7, 32, 20);

    // div 7 evenly spaced: offsets 0,1,3,5, 3 high / 4 low
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    cfg_mode  = 1'b0;
    run_check("d7_pre", 10, 0, 2, 5, 7, 52, 1);
    cfg_valid = 1'b0;
    settle_wait("d7");
    run_check("d7", 7, 0, 1, 3, 5, 0, 21);

    // div 8 aligned: all channels identical
    cfg_valid = 1'b1;
    cfg_div   = 8'd8;
    cfg_mode  = 1'b1;
    run_check("d8_pre", 7, 0, 1, 3, 5, 21, 1);
    cfg_valid = 1'b0;
    settle_wait("d8");
    chk("d8_first_outclk", 32'(outclk), 32'hF);
    chk("d8_first_clk_en", 32'(clk_en), 32'hF);
    run_check("d8", 8, 0, 0, 0, 0, 0, 17);

    // Request held through SETTLE transfers on the first locked cycle, exactly once
    cfg_valid = 1'b1;
    cfg_div   = 8'd10;
    cfg_mode  = 1'b0;
    run_check("hold_pre", 8, 0, 0, 0, 0, 17, 1);
    cfg_div   = 8'd5;
    settle_wait("hold");
    run_check("hold_first", 10, 0, 2, 5, 7, 0, 1);
    cfg_valid = 1'b0;
    settle_wait("d5");
    run_check("d5", 5, 0, 1, 2, 3, 0, 15);

    // One-cycle reset mid-period after div 7 restores the default configuration
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    run_check("d7b_pre", 5, 0, 1, 2, 3, 15, 1);
    cfg_valid = 1'b0;
    settle_wait("d7b");
    run_check("d7b", 7, 0, 1, 3, 5, 0, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err", 32'(cfg_err), 32'd0);
    settle_wait("rst2");
    chk("rst2_first_outclk", 32'(outclk), 32'h9);
    run_check("rel2", 10, 0, 2, 5, 7, 0, 25);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_phase_gen.md
ADC_PHASE_GEN -- requirements
Module: adc_phase_gen

Interface
REQ-001 The block SHALL have parameter NUM_CLKS, default 4, giving the number of phase channels; legal values are 1, 2, 4 and 8.
REQ-002 The block SHALL have parameter DIV_W, default 8, giving the width of the divide ratio.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 10, giving the divide ratio loaded at reset.
REQ-004 The block SHALL have parameter LOCK_CYCLES, default 16, giving the settle duration in refclk cycles.
REQ-005 The block SHALL have port refclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: a reconfiguration request.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block accepts a request in this cycle.
REQ-009 The block SHALL have port cfg_div, input, DIV_W bits: the requested divide ratio.
REQ-010 The block SHALL have port cfg_mode, input, 1 bit: 0 = evenly spaced phases, 1 = all channels aligned.
REQ-011 The block SHALL have port cfg_err, output, 1 bit: a one-cycle pulse marking a rejected request.
REQ-012 The block SHALL have port outclk, output, NUM_CLKS bits: divided square-wave clocks, registered.
REQ-013 The block SHALL have port clk_en, output, NUM_CLKS bits: a one-cycle strobe at each outclk rising edge.
REQ-014 The block SHALL have port locked, output, 1 bit: outputs are valid and running.

Function
REQ-015 The block SHALL hold an active configuration {div, mode} and run a state machine with states SETTLE and LOCKED.
REQ-016 In SETTLE the block SHALL:
- hold period counter cnt at 0;
- drive outclk=0, clk_en=0, locked=0, cfg_ready=0;
- count exactly LOCK_CYCLES cycles, then enter LOCKED.
REQ-017 The per-channel offset SHALL be computed during SETTLE and registered:
- mode=0: off[k] = (k*div) >> log2(NUM_CLKS), using floor;
- mode=1: off[k] = 0.
REQ-018 In LOCKED, cnt SHALL increment each cycle and wrap from div-1 to 0.
REQ-019 The local phase SHALL be ph[k] = (cnt - off[k]) mod div, computed as cnt-off[k] if cnt>=off[k], else cnt+div-off[k].
REQ-020 Outputs SHALL follow cnt with 1-cycle registered latency: outclk[k]=1 iff ph[k] < (div>>1), and clk_en[k]=1 iff ph[k]==0.
REQ-021 For odd div, outclk high time SHALL be floor(div/2) cycles and low time ceil(div/2) cycles.
REQ-022 locked SHALL be registered and aligned so that the first cycle with locked=1 has outclk[0]=1 and clk_en[0]=1.
REQ-023 locked SHALL remain 1 throughout LOCKED.
REQ-024 cfg_ready SHALL equal 1 only while in LOCKED.
REQ-025 A transfer SHALL occur on cfg_valid & cfg_ready in the same cycle.
REQ-026 A valid request (2 <= cfg_div, NUM_CLKS <= cfg_div) SHALL load {cfg_div, cfg_mode}; the next cycle SHALL be SETTLE with locked=0 and outputs 0.
REQ-027 An invalid request (cfg_div < 2 or cfg_div < NUM_CLKS) SHALL:
- be consumed;
- pulse cfg_err for exactly 1 cycle, the cycle after transfer;
- leave config, state, cnt and outputs undisturbed.
REQ-028 cfg_valid asserted while in SETTLE SHALL be ignored; the requester holds it until cfg_ready.
REQ-029 A valid request whose div and mode equal the active configuration SHALL still re-enter SETTLE.
REQ-030 All arithmetic SHALL be unsigned DIV_W bits.
REQ-031 The product k*div SHALL use DIV_W+3 bits before the shift, so no overflow occurs.

Reset
REQ-032 While rst=1 the block SHALL load div=DEFAULT_DIV, mode=0, cnt=0 and state SETTLE with the settle count cleared.
REQ-033 While rst=1 the block SHALL drive outclk=0, clk_en=0, locked=0, cfg_ready=0 and cfg_err=0.
REQ-034 On the first cycle with rst=0 the block SHALL begin the LOCK_CYCLES settle.
REQ-035 rst asserted at any point, mid-settle or mid-period included, SHALL take effect at the next clock edge and override any transfer.
REQ-036 A DEFAULT_DIV below NUM_CLKS or below 2 SHALL be a parameter error flagged at elaboration.

Verification
REQ-037 Reset release with defaults SHALL give:
- locked rising 16 cycles after rst falls;
- offsets 0,2,5,7;
- outclk period 10 with 5 cycles high;
- clk_en[0..3] strobing 0,2,5,7 cycles after the locked edge, then every 10 cycles.
REQ-038 A request of cfg_div=7, mode=0 while locked SHALL give:
- locked=0 and outputs 0 the next cycle;
- 16 settle cycles;
- period 7, 3 high and 4 low, offsets 0,1,3,5.
REQ-039 A request of cfg_div=3 (< NUM_CLKS=4) SHALL pulse cfg_err once and leave locked, the period-10 waveforms and the phases unbroken.
REQ-040 A request of cfg_div=8, mode=1 SHALL settle, after which all four outclk are identical and clk_en strobes simultaneously every 8 cycles.
REQ-041 cfg_valid held during SETTLE SHALL see cfg_ready=0 until locked; the transfer occurs in the first locked cycle and exactly one reconfiguration follows.
REQ-042 rst asserted for 1 cycle mid-period after a div=7 configuration SHALL restore div=10, drop all outputs next cycle and relock per REQ-037.
